// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: issues data-memory requests for loads/stores, extracts load lanes,
// and registers the writeback buffer, with misalignment and response-timeout faults.
package rv32_mem_pkg;

   typedef enum logic [3:0] {
      MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
   } mem_op_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       reg_write;
      mem_op_t    mem_op;
   } decoded_instr_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    mem_addr;
      logic [31:0]    wb_result;
   } exec_mem_buffer_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    wb_result;
      logic           fault;
   } mem_wb_buffer_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   function automatic decoded_instr_t create_nop_ctrl();
      decoded_instr_t c;
      c = '0;
      c.mem_op = MEM_NONE;
      return c;
   endfunction

endpackage

module rv32_mem_stage
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  exec_mem_buffer_t exec_mem_buff,
   output mem_wb_buffer_t   mem_wb_buff,
   output logic [31:0]      wb_bypass,
   output logic             mem_busy,
   output logic             dmem_req_valid,
   input  logic             dmem_req_ready,
   output logic [31:0]      dmem_addr,
   output logic             dmem_we,
   output logic [3:0]       dmem_be,
   output logic [31:0]      dmem_wdata,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

   mem_state_t     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   mem_op_t        op;
   logic [31:0]    addr;
   logic [31:0]    wb_in;
   logic           is_load, is_store, is_mem, is_word, is_half;
   logic           aligned, active, timed_out;
   logic           req_valid, done, to_fault, busy_int;
   logic [31:0]    rshift;
   logic [7:0]     byte_v;
   logic [15:0]    half_v;
   logic [31:0]    load_data;
   mem_wb_buffer_t nxt;

   assign op    = exec_mem_buff.decoded_instr.mem_op;
   assign addr  = exec_mem_buff.mem_addr;
   assign wb_in = exec_mem_buff.wb_result;

   always_comb begin
      is_load   = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
      is_store  = op inside {MEM_SB, MEM_SH, MEM_SW};
      is_mem    = is_load | is_store;
      is_word   = op inside {MEM_LW, MEM_SW};
      is_half   = op inside {MEM_LH, MEM_LHU, MEM_SH};
      aligned   = is_word ? (addr[1:0] == 2'b00) : (is_half ? !addr[0] : 1'b1);
      active    = is_mem && aligned;
      timed_out = (state_q != IDLE) && (cnt_q >= T_LIM);
   end

   // Handshake: a request transfers on a cycle where dmem_req_valid && dmem_req_ready;
   // until then address, we, be and wdata stay stable because upstream holds the op.
   // Read data is taken on any cycle of the accepted load where dmem_rvalid is high.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_valid = 1'b0;
      done      = 1'b0;
      to_fault  = 1'b0;
      if (!active) begin
         done    = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (timed_out) begin
         done     = 1'b1;
         to_fault = 1'b1;
         state_d  = IDLE;
         cnt_d    = '0;
      end else begin
         case (state_q)
            IDLE, REQ: begin
               req_valid = 1'b1;
               if (dmem_req_ready) begin
                  if (is_store || dmem_rvalid) begin
                     done    = 1'b1;
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = REQ;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  done    = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign busy_int       = active && !done;
   assign mem_busy       = busy_int && !reset;
   assign dmem_req_valid = req_valid && !reset;
   assign dmem_addr      = {addr[31:2], 2'b00};
   assign dmem_we        = is_store;
   assign wb_bypass      = mem_wb_buff.wb_result;

   always_comb begin
      dmem_be    = 4'b0000;
      dmem_wdata = 32'h0;
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: dmem_be = 4'b0001 << addr[1:0];
         MEM_LH, MEM_LHU, MEM_SH: dmem_be = addr[1] ? 4'b1100 : 4'b0011;
         MEM_LW, MEM_SW:          dmem_be = 4'b1111;
         default:                 dmem_be = 4'b0000;
      endcase
      case (op)
         MEM_SB:  dmem_wdata = {4{wb_in[7:0]}};
         MEM_SH:  dmem_wdata = {2{wb_in[15:0]}};
         MEM_SW:  dmem_wdata = wb_in;
         default: dmem_wdata = 32'h0;
      endcase
   end

   always_comb begin
      rshift    = dmem_rdata >> {addr[1:0], 3'b000};
      byte_v    = rshift[7:0];
      half_v    = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      case (op)
         MEM_LB:  load_data = {{24{byte_v[7]}}, byte_v};
         MEM_LBU: load_data = {24'h0, byte_v};
         MEM_LH:  load_data = {{16{half_v[15]}}, half_v};
         MEM_LHU: load_data = {16'h0, half_v};
         default: load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      nxt.instr         = exec_mem_buff.instr;
      nxt.pc            = exec_mem_buff.pc;
      nxt.decoded_instr = exec_mem_buff.decoded_instr;
      nxt.wb_result     = wb_in;
      nxt.fault         = 1'b0;
      if (busy_int) begin
         nxt.instr         = RV_NOP;
         nxt.decoded_instr = create_nop_ctrl();
         nxt.wb_result     = 32'h0;
      end else if (is_mem && !aligned) begin
         nxt.fault                   = 1'b1;
         nxt.decoded_instr.reg_write = 1'b0;
      end else if (to_fault) begin
         nxt.fault                   = 1'b1;
         nxt.wb_result               = 32'h0;
         nxt.decoded_instr.reg_write = 1'b0;
      end else if (active && is_load) begin
         nxt.wb_result = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q                   <= IDLE;
         cnt_q                     <= '0;
         mem_wb_buff.instr         <= RV_NOP;
         mem_wb_buff.pc            <= 32'h0;
         mem_wb_buff.decoded_instr <= create_nop_ctrl();
         mem_wb_buff.wb_result     <= 32'h0;
         mem_wb_buff.fault         <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_wb_buff <= nxt;
      end
   end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage: a vector table of single-cycle accesses plus
// hand-written stall, wait, timeout and reset-in-flight sequences.
module tb_rv32_mem_stage;
   import rv32_mem_pkg::*;

   logic             clk;
   logic             reset;
   exec_mem_buffer_t exec_mem_buff;
   mem_wb_buffer_t   mem_wb_buff;
   logic [31:0]      wb_bypass;
   logic             mem_busy;
   logic             dmem_req_valid;
   logic             dmem_req_ready;
   logic [31:0]      dmem_addr;
   logic             dmem_we;
   logic [3:0]       dmem_be;
   logic [31:0]      dmem_wdata;
   logic             dmem_rvalid;
   logic [31:0]      dmem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] pc_ctr = 32'h80;
   logic [31:0] exp_q[$];

   rv32_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .exec_mem_buff  (exec_mem_buff),
      .mem_wb_buff    (mem_wb_buff),
      .wb_bypass      (wb_bypass),
      .mem_busy       (mem_busy),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_rvalid    (dmem_rvalid),
      .dmem_rdata     (dmem_rdata)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exec_mem_buffer_t mk_exec(input mem_op_t op, input logic [31:0] addr,
                                                input logic [31:0] wb, input logic [31:0] pc);
      exec_mem_buffer_t e;
      e.instr                   = 32'h0000_0003 | (32'(op) << 12);
      e.pc                      = pc;
      e.decoded_instr.rd        = 5'd5;
      e.decoded_instr.rs1       = 5'd1;
      e.decoded_instr.rs2       = 5'd2;
      e.decoded_instr.reg_write = !(op inside {MEM_SB, MEM_SH, MEM_SW});
      e.decoded_instr.mem_op    = op;
      e.mem_addr                = addr;
      e.wb_result               = wb;
      return e;
   endfunction

   // driver
   task automatic drive(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wb);
      exec_mem_buff = mk_exec(op, addr, wb, pc_ctr);
      pc_ctr        = pc_ctr + 32'd4;
   endtask

   typedef struct {
      string       name;
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] wb_in;
      logic [31:0] rdata;
      logic        exp_req;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_wb;
      logic        exp_fault;
      logic        exp_rw;
   } vec_t;

   function automatic vec_t mkv(input string name, input mem_op_t op, input logic [31:0] addr,
                                input logic [31:0] wb_in, input logic [31:0] rdata,
                                input logic exp_req, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                                input logic exp_fault, input logic exp_rw);
      vec_t v;
      v.name = name; v.op = op; v.addr = addr; v.wb_in = wb_in; v.rdata = rdata;
      v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      v.exp_wb = exp_wb; v.exp_fault = exp_fault; v.exp_rw = exp_rw;
      return v;
   endfunction

   vec_t vecs[15];

   initial begin
      logic [31:0] sh_instr;
      logic [31:0] got;
      int          busy_cnt;
      bit          done_seen;

      // Single-cycle cases: memory answers ready and rvalid in the op's first cycle.
      vecs[0]  = mkv("lw_100",     MEM_LW,   32'h100, 32'h0,        32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 1);
      vecs[1]  = mkv("lb_103",     MEM_LB,   32'h103, 32'h0,        32'h80112233, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 1);
      vecs[2]  = mkv("lbu_103",    MEM_LBU,  32'h103, 32'h0,        32'h80112233, 1, 4'b1000, 32'h0,        32'h00000080, 0, 1);
      vecs[3]  = mkv("lh_102",     MEM_LH,   32'h102, 32'h0,        32'h80112233, 1, 4'b1100, 32'h0,        32'hFFFF8011, 0, 1);
      vecs[4]  = mkv("lhu_100",    MEM_LHU,  32'h100, 32'h0,        32'h80112233, 1, 4'b0011, 32'h0,        32'h00002233, 0, 1);
      vecs[5]  = mkv("lb_101",     MEM_LB,   32'h101, 32'h0,        32'h80112233, 1, 4'b0010, 32'h0,        32'h00000022, 0, 1);
      vecs[6]  = mkv("sb_101",     MEM_SB,   32'h101, 32'h000000A5, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 32'h000000A5, 0, 0);
      vecs[7]  = mkv("sw_200",     MEM_SW,   32'h200, 32'h12345678, 32'h0,        1, 4'b1111, 32'h12345678, 32'h12345678, 0, 0);
      vecs[8]  = mkv("sh_100",     MEM_SH,   32'h100, 32'h0000ABCD, 32'h0,        1, 4'b0011, 32'hABCDABCD, 32'h0000ABCD, 0, 0);
      vecs[9]  = mkv("sb_103",     MEM_SB,   32'h103, 32'h1234565A, 32'h0,        1, 4'b1000, 32'h5A5A5A5A, 32'h1234565A, 0, 0);
      vecs[10] = mkv("alu_pass",   MEM_NONE, 32'h101, 32'hCAFEF00D, 32'h99999999, 0, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 1);
      vecs[11] = mkv("lw_mis_101", MEM_LW,   32'h101, 32'h11111111, 32'h99999999, 0, 4'b0000, 32'h0,        32'h11111111, 1, 0);
      vecs[12] = mkv("lh_mis_103", MEM_LH,   32'h103, 32'h22222222, 32'h99999999, 0, 4'b0000, 32'h0,        32'h22222222, 1, 0);
      vecs[13] = mkv("sw_mis_102", MEM_SW,   32'h102, 32'h33333333, 32'h99999999, 0, 4'b0000, 32'h0,        32'h33333333, 1, 0);
      vecs[14] = mkv("lhu_mis_101",MEM_LHU,  32'h101, 32'h44444444, 32'h99999999, 0, 4'b0000, 32'h0,        32'h44444444, 1, 0);

      // Reset: a ready memory and a pending LW must not leak through while reset is high.
      reset          = 1'b1;
      dmem_req_ready = 1'b1;
      dmem_rvalid    = 1'b1;
      dmem_rdata     = 32'hDEADBEEF;
      drive(MEM_LW, 32'h100, 32'h0);
      @(negedge clk);
      #1;
      check("rst_req_valid", 32'(dmem_req_valid), 32'h0);
      check("rst_busy", 32'(mem_busy), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_instr", mem_wb_buff.instr, RV_NOP);
      check("rst_pc", mem_wb_buff.pc, 32'h0);
      check("rst_wb", mem_wb_buff.wb_result, 32'h0);
      check("rst_fault", 32'(mem_wb_buff.fault), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0;

      // Vector table
      for (int i = 0; i < 15; i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].op, vecs[i].addr, vecs[i].wb_in);
         dmem_req_ready = 1'b1;
         dmem_rvalid    = 1'b1;
         dmem_rdata     = vecs[i].rdata;
         #1;
         check({vecs[i].name, "_req_valid"}, 32'(dmem_req_valid), 32'(vecs[i].exp_req));
         check({vecs[i].name, "_busy"}, 32'(mem_busy), 32'h0);
         if (vecs[i].exp_req) begin
            check({vecs[i].name, "_addr"}, dmem_addr, {vecs[i].addr[31:2], 2'b00});
            check({vecs[i].name, "_we"}, 32'(dmem_we), 32'(vecs[i].op inside {MEM_SB, MEM_SH, MEM_SW}));
            check({vecs[i].name, "_be"}, 32'(dmem_be), 32'(vecs[i].exp_be));
            if (dmem_we) check({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
         end
         @(posedge clk);
         #1;
         check({vecs[i].name, "_wb"}, mem_wb_buff.wb_result, vecs[i].exp_wb);
         check({vecs[i].name, "_bypass"}, wb_bypass, vecs[i].exp_wb);
         check({vecs[i].name, "_fault"}, 32'(mem_wb_buff.fault), 32'(vecs[i].exp_fault));
         check({vecs[i].name, "_rw"}, 32'(mem_wb_buff.decoded_instr.reg_write), 32'(vecs[i].exp_rw));
         check({vecs[i].name, "_pc"}, mem_wb_buff.pc, pc_ctr - 32'd4);
      end

      // SH at 0x102 stalled three cycles by ready low: three bubbles then the store.
      @(negedge clk);
      drive(MEM_SH, 32'h102, 32'h0000ABCD);
      sh_instr       = exec_mem_buff.instr;
      dmem_req_ready = 1'b0;
      dmem_rvalid    = 1'b0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000ABCD);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) dmem_req_ready = 1'b1;
         #1;
         check("sh_busy", 32'(mem_busy), (c < 3) ? 32'h1 : 32'h0);
         check("sh_req_valid", 32'(dmem_req_valid), 32'h1);
         check("sh_addr", dmem_addr, 32'h100);
         check("sh_be", 32'(dmem_be), 32'hC);
         check("sh_wdata", dmem_wdata, 32'hABCDABCD);
         @(posedge clk);
         #1;
         got = exp_q.pop_front();
         check("sh_wb", mem_wb_buff.wb_result, got);
         check("sh_instr", mem_wb_buff.instr, (c < 3) ? RV_NOP : sh_instr);
         @(negedge clk);
      end

      // LW accepted, one wait cycle, then rvalid.
      drive(MEM_LW, 32'h300, 32'h0);
      dmem_req_ready = 1'b1;
      dmem_rvalid    = 1'b0;
      #1;
      check("wait_busy0", 32'(mem_busy), 32'h1);
      check("wait_req0", 32'(dmem_req_valid), 32'h1);
      @(posedge clk);
      #1;
      check("wait_bubble", mem_wb_buff.instr, RV_NOP);
      check("wait_state", 32'(dut.state_q), 32'(WAIT));
      @(negedge clk);
      dmem_req_ready = 1'b0;
      #1;
      check("wait_req1", 32'(dmem_req_valid), 32'h0);
      check("wait_busy1", 32'(mem_busy), 32'h1);
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0BADF00D;
      #1;
      check("wait_busy2", 32'(mem_busy), 32'h0);
      @(posedge clk);
      #1;
      check("wait_wb", mem_wb_buff.wb_result, 32'h0BADF00D);
      check("wait_fault", 32'(mem_wb_buff.fault), 32'h0);

      // LW accepted, rvalid never arrives: four busy cycles then a timeout fault.
      @(negedge clk);
      drive(MEM_LW, 32'h400, 32'h55555555);
      dmem_req_ready = 1'b1;
      dmem_rvalid    = 1'b0;
      busy_cnt       = 0;
      done_seen      = 1'b0;
      for (int c = 0; c < 20 && !done_seen; c++) begin
         #1;
         if (mem_busy) busy_cnt++;
         else done_seen = 1'b1;
         if (!done_seen) begin
            @(posedge clk);
            @(negedge clk);
            dmem_req_ready = 1'b0;
         end
      end
      check("to_done_seen", 32'(done_seen), 32'h1);
      check("to_busy_cycles", 32'(busy_cnt), 32'd4);
      @(posedge clk);
      #1;
      check("to_fault", 32'(mem_wb_buff.fault), 32'h1);
      check("to_wb", mem_wb_buff.wb_result, 32'h0);
      check("to_rw", 32'(mem_wb_buff.decoded_instr.reg_write), 32'h0);
      check("to_state", 32'(dut.state_q), 32'(IDLE));

      // Reset while waiting; a later rvalid must not complete the abandoned load.
      @(negedge clk);
      drive(MEM_LW, 32'h500, 32'h0);
      dmem_req_ready = 1'b1;
      dmem_rvalid    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset          = 1'b1;
      dmem_req_ready = 1'b0;
      #1;
      check("rw_req_valid", 32'(dmem_req_valid), 32'h0);
      check("rw_busy", 32'(mem_busy), 32'h0);
      @(posedge clk);
      #1;
      check("rw_state", 32'(dut.state_q), 32'(IDLE));
      check("rw_instr", mem_wb_buff.instr, RV_NOP);
      check("rw_pc", mem_wb_buff.pc, 32'h0);
      @(negedge clk);
      reset       = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hFFFFFFFF;
      #1;
      check("rw_busy_after", 32'(mem_busy), 32'h1);
      @(posedge clk);
      #1;
      check("rw_ignored_wb", mem_wb_buff.wb_result, 32'h0);
      check("rw_ignored_instr", mem_wb_buff.instr, RV_NOP);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      drive(MEM_NONE, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
